// File: rtl/jtag_vdr_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_vdr_responder_if
// Brief    : TCK-domain byte stream between the JTAG responder and fabric.
// Revision : 1.0
// ============================================================================
interface jtag_vdr_responder_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;

    // Fabric side: offers TX bytes, consumes RX bytes.
    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );

    // Responder side.
    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output rx_data,
        output rx_valid
    );
endinterface
`default_nettype wire

// File: rtl/jtag_vdr_responder.sv
`default_nettype none
// ============================================================================
// Module   : jtag_vdr_responder
// Brief    : Virtual JTAG DR responder: DATA/LOOPBACK/DEBUG/INFO/CONTROL modes.
// Revision : 1.0
// ============================================================================
module jtag_vdr_responder #(
    parameter logic [15:0] INFO_WORD  = 16'h0A01,
    parameter logic [7:0]  IDLE_BYTE  = 8'h4A,
    parameter int          CTRL_WIDTH = 8
) (
    input  wire                   tck,
    input  wire                   reset,
    input  wire [2:0]             ir_in,
    input  wire                   virtual_state_cdr,
    input  wire                   virtual_state_sdr,
    input  wire                   virtual_state_udr,
    input  wire                   tdi,
    output logic                  tdo,
    output logic [2:0]            ir_out,
    jtag_vdr_responder_if.slave   bs,
    output logic [CTRL_WIDTH-1:0] ctrl
);

    typedef enum logic [2:0] {
        MODE_DATA  = 3'd0,
        MODE_LOOP  = 3'd1,
        MODE_DEBUG = 3'd2,
        MODE_INFO  = 3'd3,
        MODE_CTRL  = 3'd4
    } mode_e;

    logic [15:0]           r_sr;
    logic [2:0]            r_cnt;
    logic [7:0]            r_txb;
    logic                  r_txb_full;
    logic [7:0]            r_rx_data;
    logic                  r_rx_valid;
    logic [15:0]           r_rx_count;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic                  r_bypass;

    mode_e                 w_mode;
    logic                  w_do_cdr;
    logic                  w_do_sdr;
    logic                  w_do_udr;
    logic                  w_byte_done;
    logic                  w_reload;
    logic                  w_accept;
    logic [7:0]            w_next_tx;
    logic [7:0]            w_data_shift;
    logic [CTRL_WIDTH-1:0] w_ctrl_shift;

    always_comb begin
        w_mode = MODE_LOOP;
        case (ir_in)
            3'd0:    w_mode = MODE_DATA;
            3'd2:    w_mode = MODE_DEBUG;
            3'd3:    w_mode = MODE_INFO;
            3'd4:    w_mode = MODE_CTRL;
            default: w_mode = MODE_LOOP;
        endcase
    end

    // Only one strobe acts per cycle: cdr wins over sdr, sdr over udr.
    assign w_do_cdr     = virtual_state_cdr;
    assign w_do_sdr     = virtual_state_sdr && !virtual_state_cdr;
    assign w_do_udr     = virtual_state_udr && !virtual_state_sdr && !virtual_state_cdr;

    assign w_byte_done  = (w_mode == MODE_DATA) && w_do_sdr && (r_cnt == 3'd7);
    assign w_reload     = ((w_mode == MODE_DATA) && w_do_cdr) || w_byte_done;
    assign w_accept     = bs.tx_valid && !r_txb_full;
    assign w_next_tx    = r_txb_full ? r_txb : IDLE_BYTE;
    assign w_data_shift = {tdi, r_sr[7:1]};

    generate
        if (CTRL_WIDTH == 1) begin : g_ctrl_w1
            assign w_ctrl_shift = tdi;
        end else begin : g_ctrl_wn
            assign w_ctrl_shift = {tdi, r_sr[CTRL_WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge tck or posedge reset) begin
        if (reset) begin
            r_sr       <= '0;
            r_cnt      <= '0;
            r_txb      <= '0;
            r_txb_full <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_count <= '0;
            r_ctrl     <= '0;
            r_bypass   <= 1'b0;
        end else begin
            r_rx_valid <= w_byte_done;

            // A reload takes the old buffer contents before a same-cycle accept refills it.
            if (w_accept) begin
                r_txb      <= bs.tx_data;
                r_txb_full <= 1'b1;
            end else if (w_reload) begin
                r_txb_full <= 1'b0;
            end

            if (w_do_cdr) begin
                case (w_mode)
                    MODE_DATA: begin
                        r_cnt     <= '0;
                        r_sr[7:0] <= w_next_tx;
                    end
                    MODE_DEBUG: r_sr <= r_rx_count;
                    MODE_INFO:  r_sr <= INFO_WORD;
                    MODE_CTRL:  r_sr[CTRL_WIDTH-1:0] <= r_ctrl;
                    default: ;
                endcase
            end else if (w_do_sdr) begin
                case (w_mode)
                    MODE_LOOP: r_bypass <= tdi;
                    MODE_DATA: begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            r_rx_data  <= w_data_shift;
                            r_rx_count <= r_rx_count + 16'd1;
                            r_sr[7:0]  <= w_next_tx;
                        end else begin
                            r_sr[7:0]  <= w_data_shift;
                        end
                    end
                    MODE_DEBUG, MODE_INFO: r_sr <= {tdi, r_sr[15:1]};
                    MODE_CTRL:  r_sr[CTRL_WIDTH-1:0] <= w_ctrl_shift;
                    default: ;
                endcase
            end else if (w_do_udr && (w_mode == MODE_CTRL)) begin
                r_ctrl <= r_sr[CTRL_WIDTH-1:0];
            end
        end
    end

    assign tdo         = (w_mode == MODE_LOOP) ? r_bypass : r_sr[0];
    assign ir_out      = {r_txb_full, (r_rx_count != 16'd0), 1'b0};
    assign bs.tx_ready = !r_txb_full;
    assign bs.rx_data  = r_rx_data;
    assign bs.rx_valid = r_rx_valid;
    assign ctrl        = r_ctrl;

endmodule
`default_nettype wire
